// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 16-bit pipelined MIPS (ALU, branch target, dest select) ending in the EX/MEM register.
// Latency: 1 cycle for non-MUL ops; MUL (EX_MUL_EN defined) takes 18 cycles, 17 of them stalled.
// Backpressure: stall (combinational) holds IF/ID and ID/EX while the multiplier is busy; EX/MEM takes bubbles meanwhile.
//
// Ports: clk/rst_n (async active-low); in_* are the ID/EX outputs (operands, sign-extended immediate,
// PC+2, rt/rd, control bits); O_* are the registered EX/MEM outputs; stall goes upstream.
// Optional feature macro: EX_MUL_EN builds the iterative shift-add multiplier and enables funct 1000 (MUL).
// Without it, funct 1000 is an undefined opcode and stall is tied low.
module execute_stage #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_PC_plus_two,
  input  logic [WIDTH-1:0] in_Read_data_1,
  input  logic [WIDTH-1:0] in_Read_data_2,
  input  logic [WIDTH-1:0] in_immediate,
  input  logic             in_ALU_Src,
  input  logic [1:0]       in_ALUOp,
  input  logic             in_RegDest,
  input  logic [2:0]       in_rt,
  input  logic [2:0]       in_rd,
  input  logic             in_MemRead,
  input  logic             in_MemWrite,
  input  logic             in_Branch,
  input  logic             in_MemtoReg,
  input  logic             in_RegWrite,
  output logic             stall,
  output logic [WIDTH-1:0] O_ALU_result,
  output logic             O_zero,
  output logic [WIDTH-1:0] O_branch_target,
  output logic [WIDTH-1:0] O_write_data,
  output logic [2:0]       O_write_reg,
  output logic             O_MemRead,
  output logic             O_MemWrite,
  output logic             O_Branch,
  output logic             O_MemtoReg,
  output logic             O_RegWrite,
  output logic             O_illegal
);

  // The multiplier retires exactly one product bit per iteration, so the
  // iteration count must match the datapath width. A mismatched build
  // elaborates this empty block as a visible marker in the hierarchy.
  if (MUL_CYCLES != WIDTH) begin : g_mul_cycles_mismatch
  end

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       funct;
  logic             illegal;
  logic             slt;

  assign op_a  = in_Read_data_1;
  assign op_b  = in_ALU_Src ? in_immediate : in_Read_data_2;
  assign funct = in_immediate[3:0];
  assign slt   = $signed(op_a) < $signed(op_b);

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mul_state_t;

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_sel;
  logic             mul_load;
  logic             mul_step;
  logic             stall_int;
`endif

  // ALU and funct decode
  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
`ifdef EX_MUL_EN
    mul_sel = 1'b0;
`endif
    case (in_ALUOp)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b11: alu_res = op_a | op_b;
      default: begin
        case (funct)
          4'b0000: alu_res = op_a + op_b;
          4'b0001: alu_res = op_a - op_b;
          4'b0010: alu_res = op_a & op_b;
          4'b0011: alu_res = op_a | op_b;
          4'b0100: alu_res = {{(WIDTH-1){1'b0}}, slt};
          4'b0101: alu_res = op_a ^ op_b;
          4'b0110: alu_res = op_a << op_b[3:0];
          4'b0111: alu_res = op_a >> op_b[3:0];
`ifdef EX_MUL_EN
          // Only the DONE-cycle value is ever registered; earlier cycles are bubbled.
          4'b1000: begin
            mul_sel = 1'b1;
            alu_res = acc_q;
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

`ifdef EX_MUL_EN
  // Multiplier state and shift-add datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (mul_load) begin
        mcand_q  <= op_a;
        mplier_q <= op_b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (mul_step) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_int = 1'b0;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mul_sel) begin
          stall_int = 1'b1;
          mul_load  = 1'b1;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_int = 1'b1;
        mul_step  = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      // ID/EX advances on this same edge, so IDLE sees the next instruction.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset must show stall low even if a MUL is sitting at the inputs.
  assign stall = stall_int & rst_n;
`else
  assign stall = 1'b0;
`endif

  // EX/MEM pipeline register; a stalled cycle loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O_ALU_result    <= '0;
      O_zero          <= 1'b0;
      O_branch_target <= '0;
      O_write_data    <= '0;
      O_write_reg     <= '0;
      O_MemRead       <= 1'b0;
      O_MemWrite      <= 1'b0;
      O_Branch        <= 1'b0;
      O_MemtoReg      <= 1'b0;
      O_RegWrite      <= 1'b0;
      O_illegal       <= 1'b0;
    end else if (stall) begin
      O_ALU_result    <= '0;
      O_zero          <= 1'b0;
      O_branch_target <= '0;
      O_write_data    <= '0;
      O_write_reg     <= '0;
      O_MemRead       <= 1'b0;
      O_MemWrite      <= 1'b0;
      O_Branch        <= 1'b0;
      O_MemtoReg      <= 1'b0;
      O_RegWrite      <= 1'b0;
      O_illegal       <= 1'b0;
    end else begin
      O_ALU_result    <= alu_res;
      O_zero          <= (op_a - op_b) == '0;
      O_branch_target <= in_PC_plus_two + {in_immediate[WIDTH-2:0], 1'b0};
      O_write_data    <= in_Read_data_2;
      O_write_reg     <= in_RegDest ? in_rd : in_rt;
      O_MemRead       <= in_MemRead;
      O_MemWrite      <= in_MemWrite;
      O_Branch        <= in_Branch;
      O_MemtoReg      <= in_MemtoReg;
      O_RegWrite      <= in_RegWrite;
      O_illegal       <= illegal;
    end
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 16-bit pipelined MIPS, sitting directly after the ID/EX pipeline register and ending in its own EX/MEM register.
- Consumes the ID/EX outputs: operands, sign-extended immediate, PC+2, rt/rd and control bits.
- Performs ALU work, computes the branch target and selects the destination register.
- Registers everything the MEM stage needs.
- Optionally runs a 16-cycle iterative multiplier that stalls upstream while busy.

## Interface
Parameters:
- WIDTH, 16, datapath width.
- MUL_CYCLES, 16, multiplier iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_PC_plus_two  in  16  PC+2 of the instruction in EX
- in_Read_data_1  in  16  rs operand
- in_Read_data_2  in  16  rt operand (store data)
- in_immediate  in  16  sign-extended immediate; bits [3:0] are funct for R-type
- in_ALU_Src  in  1  1 = operand B is the immediate
- in_ALUOp  in  2  00 add, 01 sub, 10 R-type funct decode, 11 OR
- in_RegDest  in  1  1 = destination is rd, 0 = rt
- in_rt, in_rd  in  3  register fields
- in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite  in  1  control bits
- stall  out  1  holds IF/ID and ID/EX (combinational)
- O_ALU_result  out  16  registered result
- O_zero  out  1  registered (A − B == 0)
- O_branch_target  out  16  registered PC+2 + (imm << 1)
- O_write_data  out  16  registered in_Read_data_2
- O_write_reg  out  3  registered destination register
- O_MemRead, O_MemWrite, O_Branch, O_MemtoReg, O_RegWrite  out  1  registered control bits
- O_illegal  out  1  registered: R-type with an undefined funct

## Operation
- Operand A is in_Read_data_1. Operand B is in_ALU_Src ? in_immediate : in_Read_data_2.
- R-type funct codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT (signed, result 1 or 0), 0101 XOR
  - 0110 SLL by B[3:0], 0111 SRL by B[3:0] (logical)
  - 1000 MUL (low 16 bits of the product)
  - Any other code gives result 0 and O_illegal=1; the control bits still pass through unchanged.
- Add and sub wrap modulo 2^16; there is no overflow trap.
- O_zero is computed from A − B for every opcode.
- O_branch_target = in_PC_plus_two + {in_immediate[14:0],1'b0}, modulo 2^16.
- The branch decision (O_Branch & O_zero) is made in MEM, not here.
- Multiplier FSM states: IDLE, BUSY, DONE.
  - IDLE: a MUL at the inputs sets stall=1, loads the multiplicand, multiplier and accumulator, clears the counter, and goes to BUSY.
  - BUSY: one shift-add step per cycle, with stall=1. When counter==MUL_CYCLES−1, go to DONE.
  - DONE: stall=0. EX/MEM captures the product together with the held controls. Return to IDLE.
- While stall=1, EX/MEM loads a bubble: all control outputs 0, data outputs 0.
- Upstream must keep the ID/EX outputs constant while stall=1.
- DONE → IDLE does not re-trigger on the same MUL, because ID/EX advances on that same edge.

## Timing
- Non-MUL instructions: 1-cycle latency. Inputs at edge N appear on the O_* outputs after edge N+1.
- MUL: the instruction is present for 18 cycles (IDLE detect + 16 BUSY + DONE). stall is high for 17 of them, and the result registers on the DONE edge.
- Back-to-back MULs: the second is detected in IDLE on the cycle after DONE.
- Reset (asynchronous, any time, including mid-BUSY):
  - FSM goes to IDLE and the counter clears.
  - All O_* outputs clear to 0 and stall=0.
  - A multiplication in progress is discarded.
- A bubble input (all controls 0) still computes and registers the ALU data. No state effect.

## Configuration
- EX_MUL_EN defined: the multiplier FSM is built and funct 1000 is MUL.
- EX_MUL_EN undefined:
  - The FSM is not built and stall is tied to 0.
  - Funct 1000 is treated as undefined: result 0, O_illegal=1, single cycle.

## Test plan
- Reset: assert rst_n=0 mid-cycle → every O_* output and stall read 0 immediately; FSM returns to IDLE.
- ADD R-type: A=0x7FFF, B=0x0001, funct 0000 → next cycle O_ALU_result=0x8000, O_zero=0, O_write_reg=rd.
- BEQ: ALUOp=01, A=B=0x1234, in_PC_plus_two=0x0010, imm=0xFFFE → O_zero=1, O_branch_target=0x000C, O_Branch=1.
- SLT/SRL: A=0xFFFF, B=0x0001 → SLT gives 1. Then A=0x8000, B=0x0003 with SRL → 0x1000.
- MUL (EX_MUL_EN): A=0x0123, B=0x0045 → stall high 17 cycles, bubbles on the outputs, then O_ALU_result=0x4E6F and O_RegWrite=1. Reset asserted at BUSY cycle 8 → no result, stall=0.
- Funct 1001 → O_illegal=1, result 0. Without EX_MUL_EN, funct 1000 behaves the same way with stall never asserted.
